bus_read_master: RTL and testbench

Initiator side of the shared read bus. It accepts a single-word read request from local logic, drives `addr` and `rd` onto the bus, and waits for the addressed responder to assert its data-enable `den`. It captures `din`, releases the bus, and waits for `den` to drop before reporting completion. An optional timeout aborts reads that no responder claims.

---
 rtl/bus_read_master.sv | 122 ++++++++++++
 tb/tb_bus_read_master.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_read_master.sv
// Purpose : shared read bus initiator; one word per request, bus released before completion.
// Latency : 5 cycles from request accept to done with a zero-wait responder (+1 per responder wait cycle).
// Backpres: req is taken only while ready (IDLE); requests while busy are dropped, not queued.
//
// Ports:
//   clk, rst        - rising-edge clock, asynchronous active-low reset
//   req, req_addr   - local read request, sampled only while ready
//   ready           - high in IDLE (decoded from state)
//   done, err       - one-cycle completion pulse; err=1 marks a timeout abort
//   rdata           - last successfully captured read data
//   rd, addr        - registered bus read strobe and address
//   din, den        - responder data and data-enable
//
// Optional feature: define BUS_RD_TIMEOUT_EN to abort reads that no responder
// claims within TIMEOUT cycles. Without it REQ waits indefinitely and err is 0.
module bus_read_master #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic [AW-1:0] req_addr,
    output logic          ready,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] rdata,
    output logic          rd,
    output logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    input  logic          den
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    logic [1:0] state;

    assign ready = (state == S_IDLE);

`ifdef BUS_RD_TIMEOUT_EN
    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;       // REQ cycles seen without den
    logic          err_flag;  // outcome of the current read, reported with done
    logic          err_q;

    assign err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT < 2);
    assign err            = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            rd    <= 1'b0;
            addr  <= '0;
            rdata <= '0;
            done  <= 1'b0;
`ifdef BUS_RD_TIMEOUT_EN
            cnt      <= '0;
            err_flag <= 1'b0;
            err_q    <= 1'b0;
`endif
        end else begin
            // done and err are single-cycle; they clear unless re-armed below
            done <= 1'b0;
`ifdef BUS_RD_TIMEOUT_EN
            err_q <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (req) begin
                        state <= S_REQ;
                        rd    <= 1'b1;
                        addr  <= req_addr;
`ifdef BUS_RD_TIMEOUT_EN
                        cnt   <= '0;
`endif
                    end
                end
                S_REQ: begin
                    // den has priority over an expiring timeout
                    if (den) begin
                        rdata <= din;
                        rd    <= 1'b0;
                        state <= S_RELEASE;
`ifdef BUS_RD_TIMEOUT_EN
                        err_flag <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        rd       <= 1'b0;
                        err_flag <= 1'b1;
                        state    <= S_RELEASE;
                    end else begin
                        cnt <= cnt + CW'(1);
`endif
                    end
                end
                S_RELEASE: begin
                    // responder drops den one cycle after seeing rd low
                    if (!den) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
`ifdef BUS_RD_TIMEOUT_EN
                        err_q <= err_flag;
`endif
                    end
                end
                default: begin
                    state <= S_IDLE;
                    rd    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_read_master.sv
module tb_bus_read_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic [7:0] req_addr;
    logic       ready;
    logic       done;
    logic       err;
    logic [7:0] rdata;
    logic       rd;
    logic [7:0] addr;
    logic [7:0] din;
    logic       den;

    int checks = 0;
    int errors = 0;

    // responder configuration, set by the stimulus
    logic       resp_en;
    logic [7:0] resp_addr;
    logic [7:0] resp_data;
    int         resp_delay;
    int         wcnt;

    // rd low-run tracking between strobes
    int low_run  = 0;
    int last_gap = 0;

    bus_read_master #(.AW(8), .DW(8), .TIMEOUT(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_addr (req_addr),
        .ready    (ready),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .rd       (rd),
        .addr     (addr),
        .din      (din),
        .den      (den)
    );

    always #5 clk = ~clk;

    // Registered responder: waits resp_delay cycles after seeing rd && match,
    // then holds den until it sees rd low.
    initial begin
        den  = 1'b0;
        wcnt = 0;
    end
    always @(posedge clk) begin
        if (rd !== 1'b1) begin
            den  <= 1'b0;
            wcnt <= 0;
        end else if (resp_en && addr == resp_addr) begin
            if (wcnt >= resp_delay) den <= 1'b1;
            else                    wcnt <= wcnt + 1;
        end
    end
    // off-cycle data is the complement so a mistimed capture is visible
    assign din = den ? resp_data : ~resp_data;

    always @(negedge clk) begin
        if (rd === 1'b1) begin
            if (low_run > 0) last_gap = low_run;
            low_run = 0;
        end else begin
            low_run++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s", tag);
        end
    endtask

    // Called at a negedge: present a request and arm the responder.
    task automatic issue(input logic [7:0] a, input logic [7:0] d, input int dly, input bit en);
        chk("ready_idle", ready, 1);
        resp_en    = en;
        resp_addr  = a;
        resp_data  = d;
        resp_delay = dly;
        req        = 1'b1;
        req_addr   = a;
    endtask

    // Follows an issued read to its done cycle. Expected model: rd/addr visible
    // in cycle 1, done in cycle 5+dly, rdata = responder data, err = 0.
    task automatic track(input logic [7:0] a, input logic [7:0] d, input int dly, input bit busy);
        int k;
        @(negedge clk);
        if (busy) req_addr = 8'h55;
        else      req = 1'b0;
        chk("rd_c1", rd, 1);
        chk("addr_c1", addr, a);
        k = 1;
        while (done !== 1'b1 && k < 100) begin
            chk("ready_busy", ready, 0);
            chk("addr_hold", addr, a);
            @(negedge clk);
            k++;
        end
        chk("latency", k, 5 + dly);
        chk("rdata", rdata, d);
        chk("err_ok", err, 0);
        chk("ready_done", ready, 1);
        chk("rd_done", rd, 0);
    endtask

    initial begin
        logic [7:0] a;
        logic [7:0] d;
        int         dly;
        int         n;
        int         dn;

        rst = 1'b0; req = 1'b0; req_addr = '0;
        resp_en = 1'b0; resp_addr = '0; resp_data = '0; resp_delay = 0;
        #2;
        chk("rst_rd", rd, 0);
        chk("rst_addr", addr, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // basic read, then back-to-back request on the done cycle
        issue(8'h3A, 8'hC5, 0, 1'b1);
        track(8'h3A, 8'hC5, 0, 1'b0);
        issue(8'h10, 8'h77, 0, 1'b1);
        track(8'h10, 8'h77, 0, 1'b0);
        chk("b2b_gap_min2", (last_gap >= 2), 1);

        // slow responder: den 6 cycles after rd rises
        issue(8'h42, 8'h9E, 5, 1'b1);
        track(8'h42, 8'h9E, 5, 1'b0);

        // randomized reads, issued back to back
        for (int i = 0; i < 6; i++) begin
            a   = 8'($urandom);
            d   = 8'($urandom);
            dly = int'($urandom_range(0, 7));
            issue(a, d, dly, 1'b1);
            track(a, d, dly, 1'b0);
        end

        // busy request held through the read must be ignored
        issue(8'h3A, 8'hC5, 0, 1'b1);
        track(8'h3A, 8'hC5, 0, 1'b1);
        req = 1'b0;
        dn = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        chk("busy_extra_done", dn, 0);
        chk("busy_addr", addr, 8'h3A);
        chk("busy_rd", rd, 0);

        // unclaimed read
`ifdef BUS_RD_TIMEOUT_EN
        issue(8'hA5, 8'h00, 0, 1'b0);
        @(negedge clk);
        req = 1'b0;
        n = 0;
        while (rd === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("to_rd_cycles", n, 16);
        chk("to_no_done_yet", done, 0);
        @(negedge clk);
        chk("to_done", done, 1);
        chk("to_err", err, 1);
        chk("to_rdata_kept", rdata, 8'hC5);
        chk("to_ready", ready, 1);
        @(negedge clk);
        chk("to_err_clear", err, 0);
        chk("to_done_clear", done, 0);
        issue(8'h66, 8'h00, 0, 1'b0);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
`else
        issue(8'hA5, 8'h00, 0, 1'b0);
        @(negedge clk);
        req = 1'b0;
        n = 0;
        dn = 0;
        repeat (120) begin
            if (rd === 1'b1) n++;
            if (done === 1'b1) dn++;
            @(negedge clk);
        end
        chk("hang_rd_high", n, 120);
        chk("hang_no_done", dn, 0);
        chk("hang_rdata_kept", rdata, 8'hC5);
`endif

        // asynchronous reset in the middle of REQ
        chk("pre_rst_rd", rd, 1);
        #3 rst = 1'b0;
        #1;
        chk("arst_rd", rd, 0);
        chk("arst_addr", addr, 0);
        chk("arst_rdata", rdata, 0);
        chk("arst_done", done, 0);
        chk("arst_err", err, 0);
        chk("arst_ready", ready, 1);
        @(negedge clk);
        rst = 1'b1;
        dn = 0;
        repeat (10) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        chk("post_rst_no_done", dn, 0);
        chk("post_rst_ready", ready, 1);

        // recovery read after reset
        issue(8'h3A, 8'hC5, 2, 1'b1);
        track(8'h3A, 8'hC5, 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
